// File: rtl/group_word_arbiter.sv
// Round-robin arbiter granting N word producers exclusive access to the group buffer RMW port.
// A per-grant watchdog revokes a stuck grant and masks that channel until it drops its request.
module group_word_arbiter #(
  parameter int unsigned N_CH       = 5,
  parameter int unsigned DW         = 12,
  parameter int unsigned AW         = 10,
  parameter int unsigned TMO_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_CH-1:0]    ch_busy,
  output logic [N_CH-1:0]    ch_gnt,
  input  logic [N_CH*DW-1:0] ch_wdata,
  input  logic [N_CH*AW-1:0] ch_waddr,
  input  logic [N_CH-1:0]    ch_wren,
  input  logic [N_CH*AW-1:0] ch_raddr,
  input  logic [N_CH-1:0]    ch_rden,
  output logic [N_CH*DW-1:0] ch_rdata,
  output logic [DW-1:0]      comm_wdata,
  output logic [AW-1:0]      comm_waddr,
  output logic               comm_wren,
  output logic [AW-1:0]      comm_raddr,
  output logic               comm_rden,
  input  logic [DW-1:0]      comm_rdata,
  output logic               comm_busy,
  output logic [N_CH-1:0]    tmo_flag,
  input  logic               tmo_clr
);

  localparam int unsigned PW       = (N_CH <= 2) ? 1 : $clog2(N_CH);
  localparam int unsigned WDW      = (TMO_CYCLES < 2) ? 1 : $clog2(TMO_CYCLES + 1);
  localparam int unsigned TMO_LAST = (TMO_CYCLES == 0) ? 0 : TMO_CYCLES - 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

  state_e          r_state, w_state_n;
  logic [N_CH-1:0] r_gnt, w_gnt_n;
  logic [PW-1:0]   r_rr_ptr, w_rr_ptr_n;
  logic [WDW-1:0]  r_wdog, w_wdog_n;
  logic [N_CH-1:0] r_mask, w_mask_n;
  logic [N_CH-1:0] r_tmo_flag, w_tmo_flag_n;
  logic [N_CH-1:0] w_elig, w_tmo_set;
  logic            w_found;
  logic [PW-1:0]   w_win;

  assign w_elig = ch_busy & ~r_mask;

  // First eligible channel after rr_ptr, wrapping modulo N_CH
  always_comb begin
    int unsigned idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      idx = 32'(r_rr_ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_rr_ptr   <= PW'(N_CH - 1);
      r_wdog     <= '0;
      r_mask     <= '0;
      r_tmo_flag <= '0;
    end else begin
      r_state    <= w_state_n;
      r_gnt      <= w_gnt_n;
      r_rr_ptr   <= w_rr_ptr_n;
      r_wdog     <= w_wdog_n;
      r_mask     <= w_mask_n;
      r_tmo_flag <= w_tmo_flag_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_gnt_n    = r_gnt;
    w_rr_ptr_n = r_rr_ptr;
    w_wdog_n   = r_wdog;
    w_tmo_set  = '0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_gnt_n    = N_CH'(1) << w_win;
          w_rr_ptr_n = w_win;
          w_wdog_n   = '0;
          w_state_n  = GRANT;
        end
      end
      GRANT: begin
        if (r_wdog != WDW'(TMO_CYCLES)) w_wdog_n = r_wdog + WDW'(1);
        if ((ch_busy & r_gnt) == '0) begin
          w_gnt_n   = '0;
          w_state_n = GAP;
        end else if (TMO_CYCLES != 0 && r_wdog == WDW'(TMO_LAST)) begin
          w_tmo_set = r_gnt;
          w_gnt_n   = '0;
          w_state_n = GAP;
        end
      end
      GAP:     w_state_n = IDLE;
      default: begin
        w_gnt_n   = '0;
        w_state_n = IDLE;
      end
    endcase
    // A timeout set in the same cycle as tmo_clr survives the clear
    w_mask_n     = (r_mask & ch_busy) | w_tmo_set;
    w_tmo_flag_n = (tmo_clr ? '0 : r_tmo_flag) | w_tmo_set;
  end

  // One-hot grant steers the shared port; everything is zero without a grant
  always_comb begin
    comm_wdata = '0;
    comm_waddr = '0;
    comm_wren  = 1'b0;
    comm_raddr = '0;
    comm_rden  = 1'b0;
    ch_rdata   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (r_gnt[i]) begin
        comm_wdata           = ch_wdata[i*DW +: DW];
        comm_waddr           = ch_waddr[i*AW +: AW];
        comm_wren            = ch_wren[i];
        comm_raddr           = ch_raddr[i*AW +: AW];
        comm_rden            = ch_rden[i];
        ch_rdata[i*DW +: DW] = comm_rdata;
      end
    end
  end

  assign ch_gnt    = r_gnt;
  assign comm_busy = (r_state == GRANT);
  assign tmo_flag  = r_tmo_flag;

endmodule

// File: tb/tb_group_word_arbiter.sv
// Directed bench for group_word_arbiter: grant latency, round-robin order, strobe isolation,
// read return path, watchdog revoke/mask/clear and asynchronous reset during a grant.
module tb_group_word_arbiter;

  localparam int unsigned N_CH = 5;
  localparam int unsigned DW   = 12;
  localparam int unsigned AW   = 10;

  logic               clk;
  logic               reset;
  logic [N_CH-1:0]    ch_busy;
  logic [N_CH-1:0]    ch_gnt;
  logic [N_CH*DW-1:0] ch_wdata;
  logic [N_CH*AW-1:0] ch_waddr;
  logic [N_CH-1:0]    ch_wren;
  logic [N_CH*AW-1:0] ch_raddr;
  logic [N_CH-1:0]    ch_rden;
  logic [N_CH*DW-1:0] ch_rdata;
  logic [DW-1:0]      comm_wdata;
  logic [AW-1:0]      comm_waddr;
  logic               comm_wren;
  logic [AW-1:0]      comm_raddr;
  logic               comm_rden;
  logic [DW-1:0]      comm_rdata;
  logic               comm_busy;
  logic [N_CH-1:0]    tmo_flag;
  logic               tmo_clr;

  int n_assert = 0;
  int n_fail   = 0;
  int n;

  group_word_arbiter #(.N_CH(N_CH), .DW(DW), .AW(AW), .TMO_CYCLES(16)) u_dut (
    .clk(clk), .reset(reset), .ch_busy(ch_busy), .ch_gnt(ch_gnt),
    .ch_wdata(ch_wdata), .ch_waddr(ch_waddr), .ch_wren(ch_wren),
    .ch_raddr(ch_raddr), .ch_rden(ch_rden), .ch_rdata(ch_rdata),
    .comm_wdata(comm_wdata), .comm_waddr(comm_waddr), .comm_wren(comm_wren),
    .comm_raddr(comm_raddr), .comm_rden(comm_rden), .comm_rdata(comm_rdata),
    .comm_busy(comm_busy), .tmo_flag(tmo_flag), .tmo_clr(tmo_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; ch_busy = '0; ch_wdata = '0; ch_waddr = '0; ch_wren = '0;
    ch_raddr = '0; ch_rden = '0; comm_rdata = '0; tmo_clr = 1'b0;
    tick(); tick();
    chk("rst_gnt",  64'(ch_gnt), 64'h0);
    chk("rst_busy", 64'(comm_busy), 64'h0);
    chk("rst_flag", 64'(tmo_flag), 64'h0);
    chk("rst_wren", 64'(comm_wren), 64'h0);
    chk("rst_addr", 64'(comm_waddr), 64'h0);
    reset = 1'b1;
    tick();

    // Single request on ch2 with a write
    ch_busy = 5'b00100; ch_wdata[2*DW +: DW] = 12'h155; ch_waddr[2*AW +: AW] = 10'h3A; ch_wren[2] = 1'b1;
    #1;
    chk("nogrant_wren", 64'(comm_wren), 64'h0);
    chk("nogrant_gnt",  64'(ch_gnt), 64'h0);
    tick();
    chk("t1_gnt",   64'(ch_gnt), 64'h04);
    chk("t1_busy",  64'(comm_busy), 64'h1);
    chk("t1_wdata", 64'(comm_wdata), 64'h155);
    chk("t1_waddr", 64'(comm_waddr), 64'h3A);
    chk("t1_wren",  64'(comm_wren), 64'h1);
    ch_wren = '0; ch_busy = '0;
    tick();
    chk("t1_gap_gnt",  64'(ch_gnt), 64'h0);
    chk("t1_gap_busy", 64'(comm_busy), 64'h0);
    chk("t1_gap_wdat", 64'(comm_wdata), 64'h0);
    tick();

    // ch1 holds the grant while ch3 strobes a write
    ch_busy = 5'b00010; ch_wdata[1*DW +: DW] = 12'h0AA; ch_waddr[1*AW +: AW] = 10'h011;
    tick();
    chk("t3_gnt", 64'(ch_gnt), 64'h02);
    ch_busy[3] = 1'b1; ch_wren[3] = 1'b1; ch_wdata[3*DW +: DW] = 12'hFFF; ch_waddr[3*AW +: AW] = 10'h3FF;
    #1;
    chk("t3_wren",  64'(comm_wren), 64'h0);
    chk("t3_wdata", 64'(comm_wdata), 64'h0AA);
    chk("t3_waddr", 64'(comm_waddr), 64'h011);
    ch_busy = '0; ch_wren = '0;
    tick(); tick();

    // Read return path on ch4; ch0 read strobe must not leak
    ch_busy = 5'b10000; ch_rden[4] = 1'b1; ch_rden[0] = 1'b1; ch_raddr[4*AW +: AW] = 10'h2C5;
    ch_raddr[0] = 1'b1; comm_rdata = 12'hABC;
    tick();
    chk("t6_gnt",   64'(ch_gnt), 64'h10);
    chk("t6_rdata", 64'(ch_rdata), {4'h0, 12'hABC, 48'h0});
    chk("t6_rden",  64'(comm_rden), 64'h1);
    chk("t6_raddr", 64'(comm_raddr), 64'h2C5);
    ch_busy = '0; ch_rden = '0; ch_raddr = '0; comm_rdata = '0;
    tick(); tick();

    // Everyone requests; each holder releases 10 cycles after its grant then re-requests
    ch_busy = 5'b11111;
    tick();
    n = 0;
    for (int k = 0; k < 6; k++) begin
      while (ch_gnt == '0 && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("t2_gnt%0d", k), 64'(ch_gnt), 64'(5'b00001 << (k % 5)));
      if (k > 0) chk($sformatf("t2_gap%0d", k), 64'(n), 64'd3);
      repeat (9) tick();
      ch_busy[k % 5] = 1'b0;
      tick();
      chk($sformatf("t2_gapbusy%0d", k), 64'(comm_busy), 64'h0);
      if (k < 5) ch_busy[k % 5] = 1'b1;
      n = 1;
    end
    ch_busy = '0;
    tick(); tick();

    // Watchdog: ch0 sticks busy
    ch_busy = 5'b00001;
    tick();
    chk("t4_gnt", 64'(ch_gnt), 64'h01);
    n = 0;
    while (ch_gnt != '0 && n < 40) begin
      tick();
      n++;
    end
    chk("t4_hold", 64'(n), 64'd16);
    chk("t4_flag", 64'(tmo_flag), 64'h01);
    repeat (3) tick();
    chk("t4_masked", 64'(ch_gnt), 64'h0);
    tmo_clr = 1'b1;
    tick();
    tmo_clr = 1'b0;
    chk("t4_clr", 64'(tmo_flag), 64'h0);
    ch_busy = '0;
    tick();
    ch_busy = 5'b00001;
    tick();
    chk("t4_regrant", 64'(ch_gnt), 64'h01);

    // Asynchronous reset mid-grant with a write in flight
    ch_wren[0] = 1'b1;
    #1;
    chk("t5_wren_pre", 64'(comm_wren), 64'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_wren_rst", 64'(comm_wren), 64'h0);
    chk("t5_gnt_rst",  64'(ch_gnt), 64'h0);
    chk("t5_busy_rst", 64'(comm_busy), 64'h0);
    ch_wren = '0; ch_busy = 5'b00011;
    tick();
    reset = 1'b1;
    tick();
    chk("t5_rr_restart", 64'(ch_gnt), 64'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
